// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - registered packet-aware 1-to-N_CH stream demultiplexer
// Route is locked on the first beat of a packet; out-of-range selects discard the whole packet.
module stream_demux_1ton #(
  parameter  int N_CH  = 8,
  parameter  int DW    = 8,
  parameter  int CNT_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic [SEL_W-1:0] s_sel,
  input  logic             s_last,
  output logic [N_CH-1:0]  m_valid,
  input  logic [N_CH-1:0]  m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   route_ch;
  logic               out_v;
  logic [SEL_W-1:0]   out_ch;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic               sel_ok;
  logic               fwd_ready;
  logic               fwd_beat;
  logic               drop_beat;

  assign sel_ok    = (32'(s_sel) < 32'(N_CH));
  // Slot may be refilled in the same cycle its current beat drains.
  assign fwd_ready = !out_v || m_ready[out_ch];

  always_comb begin
    state_nxt = state;
    route_ch  = lock_ch;
    s_ready   = fwd_ready;
    fwd_beat  = 1'b0;
    drop_beat = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          route_ch = s_sel;
          if (s_valid && fwd_ready) begin
            fwd_beat = 1'b1;
            if (!s_last) state_nxt = ROUTE;
          end
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            drop_beat = 1'b1;
            if (!s_last) state_nxt = DROP;
          end
        end
      end
      ROUTE: begin
        if (s_valid && fwd_ready) begin
          fwd_beat = 1'b1;
          if (s_last) state_nxt = IDLE;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid) begin
          drop_beat = 1'b1;
          if (s_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_ch  <= '0;
      out_v    <= 1'b0;
      out_ch   <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fwd_beat) lock_ch <= s_sel;
      if (fwd_beat) begin
        out_v    <= 1'b1;
        out_ch   <= route_ch;
        out_data <= s_data;
        out_last <= s_last;
      end else if (out_v && m_ready[out_ch]) begin
        out_v <= 1'b0;
      end
      if (drop_beat && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    m_valid = '0;
    if (out_v) m_valid[out_ch] = 1'b1;
  end

  assign m_data = out_data;
  assign m_last = out_last;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb/tb_stream_demux_1ton.sv - directed checks for stream_demux_1ton
// Instance a: N_CH=8, CNT_W=8; instance b: N_CH=5, CNT_W=2 for drop handling.
module tb_stream_demux_1ton;

  logic       clk = 1'b0;
  logic       rst;

  logic       s_valid_a, s_ready_a, s_last_a, m_last_a;
  logic [7:0] s_data_a, m_data_a, m_valid_a, m_ready_a, drop_cnt_a;
  logic [2:0] s_sel_a;

  logic       s_valid_b, s_ready_b, s_last_b, m_last_b;
  logic [7:0] s_data_b, m_data_b;
  logic [4:0] m_valid_b, m_ready_b;
  logic [2:0] s_sel_b;
  logic [1:0] drop_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux_1ton #(.N_CH(8), .DW(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a), .s_sel(s_sel_a), .s_last(s_last_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a),
    .drop_cnt(drop_cnt_a)
  );

  stream_demux_1ton #(.N_CH(5), .DW(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_sel(s_sel_b), .s_last(s_last_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
    .drop_cnt(drop_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
    s_valid_a = v; s_sel_a = sel; s_data_a = d; s_last_a = l;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
    s_valid_b = v; s_sel_b = sel; s_data_b = d; s_last_b = l;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    m_ready_a = 8'hFF;
    m_ready_b = 5'h1F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid_a", m_valid_a, 0);
    chk("rst_data_a", m_data_a, 0);
    chk("rst_last_a", m_last_a, 0);
    chk("rst_drop_a", drop_cnt_a, 0);
    chk("rst_ready_a", s_ready_a, 1);
    chk("rst_valid_b", m_valid_b, 0);

    // T1: back-to-back single-beat packets to every channel
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 3'(i), 8'hA0 + 8'(i), 1);
      @(negedge clk);
      chk("t1_valid", m_valid_a, 32'(1) << i);
      chk("t1_data", m_data_a, 32'h0A0 + i);
      chk("t1_last", m_last_a, 1);
    end
    drive_a(0, 0, 8'h55, 0);
    @(negedge clk);
    chk("t1_drain", m_valid_a, 0);
    chk("t1_hold", m_data_a, 8'hA7);

    // T2: route locked on first beat, s_sel changes ignored
    drive_a(1, 5, 8'h10, 0);
    @(negedge clk);
    chk("t2_b0_valid", m_valid_a, 8'h20);
    chk("t2_b0_data", m_data_a, 8'h10);
    for (int i = 1; i < 4; i++) begin
      drive_a(1, 2, 8'h10 + 8'(i), (i == 3));
      @(negedge clk);
      chk("t2_valid", m_valid_a, 8'h20);
      chk("t2_data", m_data_a, 32'h10 + i);
      chk("t2_last", m_last_a, (i == 3));
    end
    drive_a(1, 2, 8'h14, 1);
    @(negedge clk);
    chk("t2_next_valid", m_valid_a, 8'h04);
    chk("t2_next_data", m_data_a, 8'h14);
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_drain", m_valid_a, 0);

    // T3: back-pressure on channel 3, other channel ready must not matter
    m_ready_a = 8'h01;
    drive_a(1, 3, 8'h30, 0);
    #1 chk("t3_ready_empty", s_ready_a, 1);
    @(negedge clk);
    chk("t3_valid0", m_valid_a, 8'h08);
    chk("t3_data0", m_data_a, 8'h30);
    drive_a(1, 3, 8'h31, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_ready_full", s_ready_a, 0);
      @(negedge clk);
      chk("t3_stall_valid", m_valid_a, 8'h08);
      chk("t3_stall_data", m_data_a, 8'h30);
    end
    m_ready_a = 8'hFF;
    #1 chk("t3_ready_resume", s_ready_a, 1);
    @(negedge clk);
    chk("t3_data1", m_data_a, 8'h31);
    chk("t3_last1", m_last_a, 0);
    drive_a(1, 3, 8'h32, 1);
    @(negedge clk);
    chk("t3_valid2", m_valid_a, 8'h08);
    chk("t3_data2", m_data_a, 8'h32);
    chk("t3_last2", m_last_a, 1);
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_drain", m_valid_a, 0);

    // T4: N_CH=5, out-of-range packet dropped, later beats' s_sel ignored
    for (int i = 0; i < 3; i++) begin
      drive_b(1, (i == 0) ? 3'd6 : 3'd1, 8'h40 + 8'(i), (i == 2));
      #1 chk("t4_drop_ready", s_ready_b, 1);
      @(negedge clk);
      chk("t4_drop_valid", m_valid_b, 0);
    end
    chk("t4_drop_cnt", drop_cnt_b, 3);
    drive_b(1, 1, 8'h50, 1);
    @(negedge clk);
    chk("t4_next_valid", m_valid_b, 5'b00010);
    chk("t4_next_data", m_data_b, 8'h50);
    drive_b(0, 0, 0, 0);

    // T5: 2-bit drop counter saturates; sel=5 is the first out-of-range value
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_cnt", drop_cnt_b, 0);
    for (int i = 0; i < 5; i++) begin
      drive_b(1, 3'd5 + 3'(i % 3), 8'h60, 1);
      @(negedge clk);
      chk("t5_cnt", drop_cnt_b, (i < 3) ? i + 1 : 3);
      chk("t5_valid", m_valid_b, 0);
    end
    drive_b(0, 0, 0, 0);

    // T6: reset mid-packet with the slot full
    m_ready_a = 8'h00;
    drive_a(1, 4, 8'h70, 0);
    @(negedge clk);
    chk("t6_pre_valid", m_valid_a, 8'h10);
    rst = 1'b1;
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid", m_valid_a, 0);
    chk("t6_data", m_data_a, 0);
    chk("t6_drop_b", drop_cnt_b, 0);
    m_ready_a = 8'hFF;
    drive_a(1, 1, 8'h71, 1);
    @(negedge clk);
    chk("t6_new_valid", m_valid_a, 8'h02);
    chk("t6_new_data", m_data_a, 8'h71);
    drive_a(0, 0, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
